cordic_phase_feeder: RTL and testbench

CORDIC_PHASE_FEEDER -- requirements
Module: cordic_phase_feeder

---
 rtl/cordic_phase_feeder.sv | 94 +++++++++
 tb/tb_cordic_phase_feeder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_phase_feeder.sv
// cordic_phase_feeder: streams I/Q samples with a per-sample accumulated phase into a
// fixed-latency CORDIC rotator, tracking each frame until its last result drains out.
module cordic_phase_feeder #(
  parameter int FRAME_LEN  = 64,
  parameter int CORDIC_LAT = 16
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        phase_init,
  input  logic [31:0]        phase_inc,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_x,
  input  logic signed [15:0] in_y,
  output logic signed [15:0] xstart,
  output logic signed [15:0] ystart,
  output logic [31:0]        zangle,
  output logic               feed_valid,
  output logic               rot_valid,
  output logic               busy,
  output logic               frame_done
);
  localparam int            DW       = $clog2(CORDIC_LAT + 1) + 1;
  localparam logic [15:0]   CNT_LAST = 16'(FRAME_LEN - 1);
  localparam logic [DW-1:0] DRN_LAST = DW'(CORDIC_LAT - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                state_q;
  logic [31:0]           acc_q, acc_d, inc_q, zangle_q;
  logic [15:0]           cnt_q;
  logic [DW-1:0]         drn_q;
  logic signed [15:0]    xstart_q, ystart_q;
  logic                  feed_valid_q, frame_done_q, xfer;
  logic [CORDIC_LAT-1:0] rot_q, rot_d;
  assign in_ready   = state_q == RUN;
  assign busy       = state_q != IDLE;
  assign xfer       = in_valid && in_ready;
  assign acc_d      = acc_q + inc_q;
  assign rot_d      = (rot_q << 1) | CORDIC_LAT'(feed_valid_q);
  assign xstart     = xstart_q;
  assign ystart     = ystart_q;
  assign zangle     = zangle_q;
  assign feed_valid = feed_valid_q;
  assign rot_valid  = rot_q[CORDIC_LAT-1];
  assign frame_done = frame_done_q;
  // The drain counter starts on the last feed cycle, so reaching CORDIC_LAT-1 lines
  // frame_done up with the last sample's rot_valid.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      inc_q        <= '0;
      cnt_q        <= '0;
      drn_q        <= '0;
      xstart_q     <= '0;
      ystart_q     <= '0;
      zangle_q     <= '0;
      feed_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      rot_q        <= '0;
    end else begin
      feed_valid_q <= xfer;
      frame_done_q <= 1'b0;
      rot_q        <= rot_d;
      if (xfer) begin
        xstart_q <= in_x;
        ystart_q <= in_y;
        zangle_q <= acc_q;
        acc_q    <= acc_d;
        cnt_q    <= cnt_q + 16'd1;
      end
      case (state_q)
        IDLE: if (start && !frame_done_q) begin
          acc_q   <= phase_init;
          inc_q   <= phase_inc;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: if (xfer && cnt_q == CNT_LAST) begin
          drn_q   <= '0;
          state_q <= DRAIN;
        end
        DRAIN: begin
          drn_q <= drn_q + DW'(1);
          if (drn_q == DRN_LAST) begin
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_phase_feeder.sv
// tb_cordic_phase_feeder: directed scenarios for the phase feeder with FRAME_LEN=4, CORDIC_LAT=16.
module tb_cordic_phase_feeder;
  localparam int FL  = 4;
  localparam int LAT = 16;
  logic               clock = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [31:0]        phase_init = 0, phase_inc = 0;
  logic signed [15:0] in_x = 0, in_y = 0;
  logic               in_ready, feed_valid, rot_valid, busy, frame_done;
  logic signed [15:0] xstart, ystart;
  logic [31:0]        zangle;
  int nc = 0, nf = 0, cyc = 0;
  int fq[$], rq[$], dq[$];
  logic [31:0] zq[$];
  logic signed [15:0] xq[$], yq[$];
  always #5 clock = ~clock;
  cordic_phase_feeder #(.FRAME_LEN(FL), .CORDIC_LAT(LAT)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .phase_init(phase_init), .phase_inc(phase_inc),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .xstart(xstart),
    .ystart(ystart), .zangle(zangle), .feed_valid(feed_valid), .rot_valid(rot_valid),
    .busy(busy), .frame_done(frame_done)
  );
  always @(negedge clock) begin
    cyc++;
    if (feed_valid) begin
      fq.push_back(cyc);
      zq.push_back(zangle);
      xq.push_back(xstart);
      yq.push_back(ystart);
    end
    if (rot_valid) rq.push_back(cyc);
    if (frame_done) dq.push_back(cyc);
  end
  task automatic clear_logs;
    fq.delete(); rq.delete(); dq.delete(); zq.delete(); xq.delete(); yq.delete();
  endtask
  task automatic drive_frame(input logic [31:0] pi, input logic [31:0] pc, input int period,
                             input logic signed [15:0] x0, input logic signed [15:0] y0,
                             input int restart_at, input bit start_at_done);
    int k = 0;
    int n = 0;
    clear_logs();
    @(negedge clock);
    start = 1; phase_init = pi; phase_inc = pc;
    @(negedge clock);
    start = 0; phase_init = ~pi; phase_inc = ~pc;
    while (n < FL && k < 200) begin
      in_valid = (k % period) == 0;
      in_x = x0 + 16'(n);
      in_y = y0 - 16'(n);
      start = (n == restart_at);
      if (start) phase_init = 32'h12345678;
      if (in_valid && in_ready) n++;
      k++;
      @(negedge clock);
    end
    in_valid = 0; start = 0;
    for (int w = 0; w < LAT + 8; w++) begin
      start = start_at_done && frame_done;
      @(negedge clock);
    end
    start = 0;
  endtask
  task automatic test_reset;
    #2;
    nc++; if (in_ready !== 1'b0) begin nf++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    nc++; if (busy !== 1'b0) begin nf++; $display("FAIL reset_busy: got %b expected 0", busy); end
    nc++; if (feed_valid !== 1'b0) begin nf++; $display("FAIL reset_feed_valid: got %b expected 0", feed_valid); end
    nc++; if (rot_valid !== 1'b0) begin nf++; $display("FAIL reset_rot_valid: got %b expected 0", rot_valid); end
    nc++; if (frame_done !== 1'b0) begin nf++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    nc++; if (zangle !== 32'h0) begin nf++; $display("FAIL reset_zangle: got %h expected 0", zangle); end
    nc++; if (xstart !== 16'sh0 || ystart !== 16'sh0) begin nf++; $display("FAIL reset_xy: got %h/%h expected 0/0", xstart, ystart); end
    @(negedge clock);
    rst_n = 1;
  endtask
  task automatic test_basic;
    logic [31:0] exp_z[4] = '{32'h00000000, 32'h40000000, 32'h80000000, 32'hC0000000};
    drive_frame(32'h0, 32'h40000000, 1, 16'sd100, -16'sd100, -1, 1'b0);
    nc++; if (fq.size() != 4) begin nf++; $display("FAIL basic_feed_count: got %0d expected 4", fq.size()); end
    for (int i = 0; i < 4 && i < zq.size(); i++) begin
      nc++; if (zq[i] !== exp_z[i]) begin nf++; $display("FAIL basic_zangle[%0d]: got %h expected %h", i, zq[i], exp_z[i]); end
      nc++; if (fq[i] != fq[0] + i) begin nf++; $display("FAIL basic_feed_cycle[%0d]: got %0d expected %0d", i, fq[i], fq[0] + i); end
      nc++; if (xq[i] !== 16'sd100 + 16'(i)) begin nf++; $display("FAIL basic_xstart[%0d]: got %0d expected %0d", i, xq[i], 100 + i); end
    end
    nc++; if (rq.size() != 4) begin nf++; $display("FAIL basic_rot_count: got %0d expected 4", rq.size()); end
    for (int i = 0; i < rq.size() && i < fq.size(); i++) begin
      nc++; if (rq[i] != fq[i] + LAT) begin nf++; $display("FAIL basic_rot_cycle[%0d]: got %0d expected %0d", i, rq[i], fq[i] + LAT); end
    end
    nc++; if (dq.size() != 1) begin nf++; $display("FAIL basic_done_count: got %0d expected 1", dq.size()); end
    if (dq.size() > 0 && rq.size() == 4) begin
      nc++; if (dq[0] != rq[3]) begin nf++; $display("FAIL basic_done_cycle: got %0d expected %0d", dq[0], rq[3]); end
    end
    nc++; if (busy !== 1'b0) begin nf++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
  endtask
  task automatic test_wrap;
    logic [31:0] exp_z[4] = '{32'hF0000000, 32'h10000000, 32'h30000000, 32'h50000000};
    drive_frame(32'hF0000000, 32'h20000000, 1, 16'sd7, 16'sd9, -1, 1'b0);
    nc++; if (fq.size() != 4) begin nf++; $display("FAIL wrap_feed_count: got %0d expected 4", fq.size()); end
    for (int i = 0; i < 4 && i < zq.size(); i++) begin
      nc++; if (zq[i] !== exp_z[i]) begin nf++; $display("FAIL wrap_zangle[%0d]: got %h expected %h", i, zq[i], exp_z[i]); end
      nc++; if (fq[i] != fq[0] + i) begin nf++; $display("FAIL wrap_feed_cycle[%0d]: got %0d expected %0d", i, fq[i], fq[0] + i); end
    end
    nc++; if (dq.size() != 1) begin nf++; $display("FAIL wrap_done_count: got %0d expected 1", dq.size()); end
  endtask
  task automatic test_backpressure;
    logic [31:0] exp_z[4] = '{32'h00001000, 32'h00001100, 32'h00001200, 32'h00001300};
    drive_frame(32'h1000, 32'h100, 3, 16'sd0, 16'sd0, -1, 1'b0);
    nc++; if (fq.size() != 4) begin nf++; $display("FAIL bp_feed_count: got %0d expected 4", fq.size()); end
    for (int i = 0; i < 4 && i < zq.size(); i++) begin
      nc++; if (zq[i] !== exp_z[i]) begin nf++; $display("FAIL bp_zangle[%0d]: got %h expected %h", i, zq[i], exp_z[i]); end
      nc++; if (fq[i] != fq[0] + 3 * i) begin nf++; $display("FAIL bp_feed_cycle[%0d]: got %0d expected %0d", i, fq[i], fq[0] + 3 * i); end
    end
    nc++; if (rq.size() != 4) begin nf++; $display("FAIL bp_rot_count: got %0d expected 4", rq.size()); end
    for (int i = 0; i < rq.size() && i < fq.size(); i++) begin
      nc++; if (rq[i] != fq[i] + LAT) begin nf++; $display("FAIL bp_rot_cycle[%0d]: got %0d expected %0d", i, rq[i], fq[i] + LAT); end
    end
    if (dq.size() > 0 && rq.size() == 4) begin
      nc++; if (dq[0] != rq[3]) begin nf++; $display("FAIL bp_done_cycle: got %0d expected %0d", dq[0], rq[3]); end
    end
  endtask
  task automatic test_start_during_run;
    logic [31:0] exp_z[4] = '{32'h00000100, 32'h00000300, 32'h00000500, 32'h00000700};
    drive_frame(32'h100, 32'h200, 1, 16'sd1, 16'sd2, 2, 1'b0);
    nc++; if (fq.size() != 4) begin nf++; $display("FAIL sdr_feed_count: got %0d expected 4", fq.size()); end
    for (int i = 0; i < 4 && i < zq.size(); i++) begin
      nc++; if (zq[i] !== exp_z[i]) begin nf++; $display("FAIL sdr_zangle[%0d]: got %h expected %h", i, zq[i], exp_z[i]); end
    end
    nc++; if (dq.size() != 1) begin nf++; $display("FAIL sdr_done_count: got %0d expected 1", dq.size()); end
    nc++; if (busy !== 1'b0) begin nf++; $display("FAIL sdr_busy_after: got %b expected 0", busy); end
  endtask
  task automatic test_start_at_done;
    drive_frame(32'h0, 32'h1, 1, 16'sd0, 16'sd0, -1, 1'b1);
    nc++; if (dq.size() != 1) begin nf++; $display("FAIL sad_done_count: got %0d expected 1", dq.size()); end
    nc++; if (busy !== 1'b0) begin nf++; $display("FAIL sad_busy_after: got %b expected 0", busy); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] exp_z[4] = '{32'h80000000, 32'h80000001, 32'h80000002, 32'h80000003};
    clear_logs();
    @(negedge clock);
    start = 1; phase_init = 32'h0; phase_inc = 32'h40000000;
    @(negedge clock);
    start = 0; in_valid = 1; in_x = 16'sd5; in_y = 16'sd6;
    @(negedge clock);
    @(negedge clock);
    in_valid = 0; rst_n = 0;
    #1;
    nc++; if (feed_valid !== 1'b0) begin nf++; $display("FAIL rmid_feed_valid: got %b expected 0", feed_valid); end
    nc++; if (zangle !== 32'h0) begin nf++; $display("FAIL rmid_zangle: got %h expected 0", zangle); end
    nc++; if (xstart !== 16'sh0 || ystart !== 16'sh0) begin nf++; $display("FAIL rmid_xy: got %h/%h expected 0/0", xstart, ystart); end
    nc++; if (busy !== 1'b0 || in_ready !== 1'b0) begin nf++; $display("FAIL rmid_busy_ready: got %b/%b expected 0/0", busy, in_ready); end
    clear_logs();
    repeat (3) @(negedge clock);
    rst_n = 1;
    repeat (LAT + 8) @(negedge clock);
    nc++; if (rq.size() != 0) begin nf++; $display("FAIL rmid_rot_after: got %0d expected 0", rq.size()); end
    nc++; if (dq.size() != 0) begin nf++; $display("FAIL rmid_done_after: got %0d expected 0", dq.size()); end
    drive_frame(32'h80000000, 32'h1, 1, 16'sd0, 16'sd0, -1, 1'b0);
    nc++; if (fq.size() != 4 || rq.size() != 4 || dq.size() != 1) begin nf++; $display("FAIL rmid_clean_counts: got %0d/%0d/%0d expected 4/4/1", fq.size(), rq.size(), dq.size()); end
    for (int i = 0; i < 4 && i < zq.size(); i++) begin
      nc++; if (zq[i] !== exp_z[i]) begin nf++; $display("FAIL rmid_zangle[%0d]: got %h expected %h", i, zq[i], exp_z[i]); end
    end
  endtask
  task automatic test_passthrough;
    drive_frame(32'h0, 32'h0, 1, -16'sd32768, 16'sd32767, -1, 1'b0);
    nc++; if (xq.size() < 1) begin nf++; $display("FAIL pt_count: got %0d expected 4", xq.size()); end
    if (xq.size() > 0) begin
      nc++; if (xq[0] !== 16'sh8000) begin nf++; $display("FAIL pt_xstart: got %h expected 8000", xq[0]); end
      nc++; if (yq[0] !== 16'sh7FFF) begin nf++; $display("FAIL pt_ystart: got %h expected 7fff", yq[0]); end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_start_during_run();
    test_start_at_done();
    test_reset_mid();
    test_passthrough();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
